ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
Keyboard-side consumer of the emulated PS/2 keyboard stream driven by the MiST IO block (ps2_kbd_clk / ps2_kbd_data). Runs in the clk_sys domain and deserialises 11-bit PS/2 frames, checking parity and stop bits. Folds E0/F0 prefixes into flags and delivers complete key events through a small FIFO with a valid/ready handshake to the BK keyboard matrix logic.

Parameters:
TIMEOUT, 2000, clk_sys cycles without a PS/2 clock falling edge before a partial frame is abandoned.
FIFO_BITS, 2, log2 of event FIFO depth (default 4 entries).

Ports:
clk_sys  in  1  system clock; same clock as the IO block.
reset_n  in  1  asynchronous, active-low reset.
ps2_clk  in  1  PS/2 clock from the IO block; idle high.
ps2_data  in  1  PS/2 data from the IO block; idle high.
key_valid  out  1  FIFO head holds an event.
key_code  out  8  scancode of head event.
key_ext  out  1  head event was E0-prefixed.
key_release  out  1  head event was F0-prefixed (break).
key_ready  in  1  consumer accepts head when key_valid=1.
parity_err  out  1  one-cycle pulse: received frame failed odd parity.
frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
overflow  out  1  sticky: an event was dropped because the FIFO was full.
clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async, reset_n=0): state IDLE, FIFO empty, prefix flags 0. Outputs: key_valid=0, key_code=0, key_ext=0, key_release=0, parity_err=0, frame_err=0, overflow=0. The synchronisers preset to 1.
- ps2_clk and ps2_data each pass through a 2-FF synchroniser of equal depth. A falling edge is synced clk 1 then 0 on consecutive cycles. Data is sampled from the synced data in that same cycle. All frame actions occur only on a falling edge.
- FSM:
  - IDLE: on an edge, data=0 moves to DATA with bit_cnt=0. Data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift the bit into shreg (LSB first) and increment bit_cnt. After the 8th bit, move to PARITY.
  - PARITY: store ok_par = (^shreg ^ bit) == 1, then move to STOP.
  - STOP: return to IDLE in all cases.
    - bit=0: pulse frame_err and discard the byte.
    - bit=1 and !ok_par: pulse parity_err and discard the byte.
    - Otherwise the byte is accepted.
  - A discarded byte clears both prefix flags.
- Timeout: a counter clears on every edge and in IDLE. If it reaches TIMEOUT while not in IDLE, go to IDLE, pulse frame_err and clear the prefix flags.
- Accepted byte:
  - 0xE0 sets ext_flag.
  - 0xF0 sets rel_flag. Flags accumulate in either order.
  - Any other byte pushes {ext_flag, rel_flag, byte} and clears both flags.
- Latency: push occurs the cycle after the stop-bit edge cycle. With the FIFO previously empty, key_valid=1 exactly 2 cycles after the stop-bit edge cycle.
- FIFO: depth 2**FIFO_BITS; outputs come from the head entry (show-ahead); pointers wrap modulo depth.
  - Pop when key_valid & key_ready.
  - Push when full without a same-cycle pop: event dropped, overflow set.
  - Push and pop in the same cycle while full: both performed, no overflow.
  - Push and pop in the same cycle while empty: push only (pop needs key_valid).
  - overflow set and clr_overflow in the same cycle: set wins.
- key_code, key_ext and key_release are held stable while key_valid=1 and no pop occurs. After the last pop they hold their last value.
- A reset mid-frame drops the partial frame, all FIFO contents and the flags.

Test Plan:
- Make code: send frame 0x1C (parity 0, stop 1) with a 40-cycle bit period. Required: key_valid rises 2 cycles after the stop edge; key_code=0x1C, ext=0, release=0; with key_ready=1 it pops and key_valid drops next cycle.
- Extended break: send E0, F0, 75. Required: exactly one event, code=0x75, ext=1, release=1; no events for the prefix bytes.
- Parity error: send 0x1C with parity bit 1. Required: a single parity_err pulse one cycle after the stop edge; no event; a following F0 1C yields release=1, ext=0.
- Overflow: with key_ready=0, send codes 01,02,03,04,05. Required: overflow=1 after the 5th frame; FIFO pops in order 01..04; clr_overflow clears it; clr_overflow held high while a 6th frame overflows gives overflow=1.
- Timeout: send start plus 3 data bits, then idle for 2000 cycles. Required: frame_err pulse and FSM in IDLE; a subsequent full 0x29 frame yields code=0x29.
- Async reset mid-frame: assert reset_n=0 during bit 4 with 2 events queued. Required: key_valid=0 immediately; after release, the next frame 0x5A is received correctly as the only event.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_if
// Key-event handshake between the PS/2 receiver and the keyboard matrix logic.
//   key_valid   : head of the event FIFO holds an event
//   key_code    : scancode of the head event
//   key_ext     : head event was E0-prefixed
//   key_release : head event was F0-prefixed (break)
//   key_ready   : consumer accepts the head event while key_valid=1
// master = event source (receiver), slave = event consumer.
// ---------------------------------------------------------------------------
interface ps2_kbd_rx_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_ready;

  modport master (
    output key_valid,
    output key_code,
    output key_ext,
    output key_release,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_ext,
    input  key_release,
    output key_ready
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// Deserialises 11-bit PS/2 keyboard frames (start, 8 data LSB first, odd
// parity, stop) in the clk_sys domain, folds E0/F0 prefixes into flags and
// queues complete key events in a small show-ahead FIFO.
// Ports:
//   clk_sys      : system clock
//   reset_n      : asynchronous active-low reset
//   ps2_clk      : PS/2 clock, idle high
//   ps2_data     : PS/2 data, idle high
//   kbd          : key-event handshake (master side)
//   parity_err   : one-cycle pulse, frame failed odd parity
//   frame_err    : one-cycle pulse, bad stop bit or timeout
//   overflow     : sticky, an event was dropped on a full FIFO
//   clr_overflow : synchronous clear of overflow
// ---------------------------------------------------------------------------
module ps2_kbd_rx #(
  parameter int TIMEOUT   = 2000,
  parameter int FIFO_BITS = 2
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_kbd_rx_if.master        kbd,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int CW    = FIFO_BITS + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // synchronisers and edge detect
  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_dat_s1, r_dat_s2;
  logic w_fall, w_bit;

  // frame FSM and datapath
  state_t          r_state, w_state_nxt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shreg;
  logic            r_ok_par;
  logic [TW-1:0]   r_to_cnt;
  logic            w_timeout;
  logic            w_frame_bad, w_par_bad, w_accept;

  // accepted byte, prefix flags
  logic            r_acc;
  logic [7:0]      r_acc_byte;
  logic            r_ext, r_rel;
  logic            r_parity_err, r_frame_err, r_overflow;

  // event FIFO
  logic [9:0]           r_mem [DEPTH];
  logic [FIFO_BITS-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CW-1:0]        r_count, w_cnt_nxt, w_left;
  logic [9:0]           r_head, w_head_nxt, w_push_data;
  logic                 w_push, w_pop, w_full, w_do_push, w_drop;

  // -------------------------------------------------------------------------
  // 2-FF synchronisers, preset to the idle-high line level
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_d & ~r_clk_s2;
  assign w_bit  = r_dat_s2;

  // -------------------------------------------------------------------------
  // Inactivity timeout: only meaningful once a frame has started
  // -------------------------------------------------------------------------
  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                                   r_to_cnt <= '0;
    else if (w_fall || r_state == S_IDLE || w_timeout) r_to_cnt <= '0;
    else                                            r_to_cnt <= r_to_cnt + TW'(1);
  end

  // -------------------------------------------------------------------------
  // Frame FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_bit) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_frame_bad = 1'b0;
    w_par_bad   = 1'b0;
    w_accept    = 1'b0;
    if (w_timeout) begin
      w_frame_bad = 1'b1;
    end else if (w_fall && r_state == S_STOP) begin
      if (!w_bit)         w_frame_bad = 1'b1;
      else if (!r_ok_par) w_par_bad   = 1'b1;
      else                w_accept    = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_bit_cnt <= 3'd0;
    else if (w_fall) begin
      if (r_state == S_IDLE)      r_bit_cnt <= 3'd0;
      else if (r_state == S_DATA) r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // shift register and parity result carry data only, no reset needed
  always_ff @(posedge clk_sys) begin
    if (w_fall && r_state == S_DATA)   r_shreg  <= {w_bit, r_shreg[7:1]};
    if (w_fall && r_state == S_PARITY) r_ok_par <= ^r_shreg ^ w_bit;
    r_acc_byte <= r_shreg;
  end

  // -------------------------------------------------------------------------
  // Error pulses, accepted byte strobe and prefix flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_acc        <= 1'b0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
    end else begin
      r_parity_err <= w_par_bad;
      r_frame_err  <= w_frame_bad;
      r_acc        <= w_accept;
      if (w_par_bad || w_frame_bad) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else if (r_acc) begin
        case (r_acc_byte)
          8'hE0:   r_ext <= 1'b1;
          8'hF0:   r_rel <= 1'b1;
          default: begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
          end
        endcase
      end
    end
  end

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

  // -------------------------------------------------------------------------
  // Event FIFO with a registered head so outputs hold after the last pop
  // -------------------------------------------------------------------------
  assign w_push      = r_acc && (r_acc_byte != 8'hE0) && (r_acc_byte != 8'hF0);
  assign w_push_data = {r_ext, r_rel, r_acc_byte};
  assign w_pop       = (r_count != '0) && kbd.key_ready;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_do_push   = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_cnt_nxt   = r_count + CW'(w_do_push) - CW'(w_pop);
  assign w_left      = r_count - CW'(w_pop);
  assign w_rd_nxt    = r_rd_ptr + FIFO_BITS'(w_pop);
  // when the queue drains this cycle the new head is the entry being pushed
  assign w_head_nxt  = (w_left == '0) ? w_push_data : r_mem[w_rd_nxt];

  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_BITS'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      if (w_cnt_nxt != '0) r_head <= w_head_nxt;
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign overflow        = r_overflow;
  assign kbd.key_valid   = (r_count != '0);
  assign kbd.key_ext     = r_head[9];
  assign kbd.key_release = r_head[8];
  assign kbd.key_code    = r_head[7:0];

endmodule
